// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared constants, fetch-state enum and opcode helper for the 16-bit core
package wisc_pkg;

  localparam logic [15:0] NOP_INSTR   = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE = 4'hF;
  localparam int          OPC_HI      = 15;
  localparam int          OPC_LO      = 12;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch sequencer bus: hazard/branch inputs, imem read port, IF/ID outputs
interface fetch_ctrl_if;

  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] im_instr;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_vld;
  logic        halted;

  modport master (
    input  stall, br_taken, br_target, im_instr,
    output im_addr, im_rd_en, ifid_instr, ifid_pc_plus1, ifid_vld, halted
  );

  modport slave (
    output stall, br_taken, br_target, im_instr,
    input  im_addr, im_rd_en, ifid_instr, ifid_pc_plus1, ifid_vld, halted
  );

endinterface

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - three saturating 16-bit event counters for fetch, stall and flush
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  input  logic        i_flush_inc,
  output logic [15:0] o_fetch_cnt,
  output logic [15:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
);

  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= 16'h0000;
      r_stall_cnt <= 16'h0000;
      r_flush_cnt <= 16'h0000;
    end else begin
      if (i_fetch_inc && (r_fetch_cnt != 16'hFFFF)) r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (i_stall_inc && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (i_flush_inc && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC owner and IF/ID register with stall, branch flush and halt.
// Optional event counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = wisc_pkg::HALT_OPCODE,
  parameter logic [15:0] NOP_INSTR   = wisc_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  fetch_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  import wisc_pkg::*;

  localparam logic [0:0] ST_FETCH = FETCH;
  localparam logic [0:0] ST_HALT  = HALT;

  logic [0:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ifid_instr;
  logic [15:0] r_ifid_pc_plus1;
  logic        r_ifid_vld;

  logic        w_in_fetch;
  logic        w_advance;
  logic        w_halt_op;
  logic [15:0] w_pc_plus1;

  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_advance  = w_in_fetch & ~bus.br_taken & ~bus.stall;
  assign w_halt_op  = (opcode_of(bus.im_instr) == HALT_OPCODE);
  assign w_pc_plus1 = r_pc + 16'd1;

  // Branch beats stall beats advance; a halt opcode freezes the PC on the halt itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_FETCH;
      r_pc            <= RESET_PC;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus1 <= 16'h0000;
      r_ifid_vld      <= 1'b0;
    end else if (w_in_fetch) begin
      if (bus.br_taken) begin
        r_pc         <= bus.br_target;
        r_ifid_instr <= NOP_INSTR;
        r_ifid_vld   <= 1'b0;
      end else if (!bus.stall) begin
        r_ifid_instr    <= bus.im_instr;
        r_ifid_pc_plus1 <= w_pc_plus1;
        r_ifid_vld      <= 1'b1;
        if (w_halt_op) r_state <= ST_HALT;
        else           r_pc    <= w_pc_plus1;
      end
    end else if (!bus.stall) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_vld   <= 1'b0;
    end
  end

  assign bus.im_addr       = r_pc;
  assign bus.im_rd_en      = w_in_fetch & ~bus.stall;
  assign bus.ifid_instr    = r_ifid_instr;
  assign bus.ifid_pc_plus1 = r_ifid_pc_plus1;
  assign bus.ifid_vld      = r_ifid_vld;
  assign bus.halted        = (r_state == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_fetch_inc (w_advance),
    .i_stall_inc (w_in_fetch & bus.stall & ~bus.br_taken),
    .i_flush_inc (w_in_fetch & bus.br_taken),
    .o_fetch_cnt (fetch_cnt),
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl against a cycle-level behavioural model
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

  fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  logic [15:0] mem [0:65535];

  // Memory latches while clk is low and holds its output when not enabled.
  always @(negedge clk) if (bus.im_rd_en === 1'b1) bus.im_instr <= mem[bus.im_addr];

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pp1;
    logic        vld;
    logic        halted;
    logic        rd_en;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_pc, m_instr, m_pp1;
  logic        m_vld, m_halted;
  int          m_fc, m_sc, m_flc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_pp1 = 16'h0000;
    m_vld = 1'b0; m_halted = 1'b0;
    m_fc = 0; m_sc = 0; m_flc = 0;
  endtask

  // Apply one cycle of inputs, record what the DUT must show this cycle, then evolve the model.
  task automatic step(input logic s, input logic b, input logic [15:0] t);
    exp_t e;
    logic [15:0] ins;
    @(posedge clk); #1;
    bus.stall = s; bus.br_taken = b; bus.br_target = t;
    e.pc = m_pc; e.instr = m_instr; e.pp1 = m_pp1;
    e.vld = m_vld; e.halted = m_halted; e.rd_en = !m_halted && !s;
    q.push_back(e);
    if (m_halted) begin
      if (!s) begin m_instr = 16'h0000; m_vld = 1'b0; end
    end else if (b) begin
      m_pc = t; m_instr = 16'h0000; m_vld = 1'b0;
      if (m_flc < 65535) m_flc++;
    end else if (s) begin
      if (m_sc < 65535) m_sc++;
    end else begin
      ins = mem[m_pc];
      m_instr = ins; m_pp1 = m_pc + 16'd1; m_vld = 1'b1;
      if (m_fc < 65535) m_fc++;
      if (ins[15:12] == 4'hF) m_halted = 1'b1;
      else                    m_pc = m_pc + 16'd1;
    end
  endtask

  // Reset asserted mid-cycle while stalled; outputs must clear without waiting for an edge.
  task automatic do_reset(input logic check_async);
    @(negedge clk); #2;
    bus.stall = 1'b1; bus.br_taken = 1'b0;
    rst = 1'b1;
    #1;
    if (check_async) begin
      check("rst_im_addr", bus.im_addr, 16'h0000);
      check("rst_ifid_instr", bus.ifid_instr, 16'h0000);
      check("rst_ifid_pc_plus1", bus.ifid_pc_plus1, 16'h0000);
      check("rst_ifid_vld", {15'b0, bus.ifid_vld}, 16'h0000);
      check("rst_halted", {15'b0, bus.halted}, 16'h0000);
      check("rst_im_rd_en", {15'b0, bus.im_rd_en}, 16'h0000);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("im_addr", bus.im_addr, e.pc);
        check("ifid_instr", bus.ifid_instr, e.instr);
        check("ifid_pc_plus1", bus.ifid_pc_plus1, e.pp1);
        check("ifid_vld", {15'b0, bus.ifid_vld}, {15'b0, e.vld});
        check("halted", {15'b0, bus.halted}, {15'b0, e.halted});
        check("im_rd_en", {15'b0, bus.im_rd_en}, {15'b0, e.rd_en});
      end
    end
  end

  initial begin : stimulus
    logic [15:0] v;
    int          budget;
    rst = 1'b1;
    bus.stall = 1'b1; bus.br_taken = 1'b0; bus.br_target = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      if (v[15:12] == 4'hF) v[15:12] = 4'hE;
      mem[i] = v;
    end
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'h6666; mem[6] = 16'hF000;
    mem[20] = 16'hF123; mem[45] = 16'hFABC;

    do_reset(1'b0);
    step(0, 0, 0); step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 1, 16'h0040);
    repeat (3) step(0, 0, 0);
    step(0, 1, 16'hFFFF);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    do_reset(1'b1);
    repeat (3) step(0, 0, 0);
    step(0, 1, 16'h0006);
    repeat (2) step(0, 0, 0);
    repeat (3) step(0, 1, 16'h0010);
    repeat (2) step(1, 0, 0);
    repeat (2) step(0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      do_reset(1'b1);
      repeat (150) step(($urandom % 4) == 0, ($urandom % 10) == 0, 16'($urandom % 64));
    end

    @(posedge clk); #1;
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 16'(m_fc));
    check("stall_cnt", stall_cnt, 16'(m_sc));
    check("flush_cnt", flush_cnt, 16'(m_flc));
`endif
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 entries left", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 16-bit pipelined core. It owns the PC and drives the instruction memory read port (address plus read enable).
- The instruction memory latches its output while clk is low, so the instruction for the address presented in a cycle is valid before the next rising edge.
- Registers the fetched instruction and its PC into the IF/ID stage.
- Handles load-use stalls, taken-branch redirect/flush, and halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, opcode field instr[15:12] that halts fetch.
- NOP_INSTR, 16'h0000, encoding injected into IF/ID on flush.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit requests hold of PC and IF/ID.
- br_taken  input  1  branch/jump resolved taken this cycle.
- br_target  input  16  redirect address, valid when br_taken=1.
- im_instr  input  16  instruction-memory read data.
- im_addr  output  16  instruction-memory address; equals pc.
- im_rd_en  output  1  instruction-memory read enable.
- ifid_instr  output  16  registered instruction to decode.
- ifid_pc_plus1  output  16  registered PC+1 of that instruction.
- ifid_vld  output  1  IF/ID holds a real (non-bubble) instruction.
- halted  output  1  fetch permanently stopped until reset.

Behaviour:
- Reset (asynchronous, immediate), values:
  - pc=RESET_PC, state=FETCH.
  - ifid_instr=NOP_INSTR, ifid_pc_plus1=0, ifid_vld=0, halted=0.
- States: FETCH and HALT.
  - FETCH→HALT when advancing and im_instr[15:12]==HALT_OPCODE and br_taken=0.
  - HALT exits only via rst.
- im_addr = pc (combinational).
- im_rd_en = (state==FETCH) & ~stall. With rd_en low the memory holds its last output, so the stalled instruction is re-presented unchanged.
- Per rising edge in FETCH, priority br_taken > stall > advance:
  - br_taken=1: pc<=br_target; ifid_instr<=NOP_INSTR; ifid_vld<=0. This is a one-bubble flush and overrides a simultaneous stall. A halt-opcode fetch in that cycle is squashed; no state change.
  - stall=1: pc, ifid_instr, ifid_pc_plus1, ifid_vld all hold.
  - Advance:
    - ifid_instr<=im_instr; ifid_pc_plus1<=pc+1; ifid_vld<=1.
    - pc<=pc+1, computed modulo 2^16 (16'hFFFF wraps to 16'h0000, no error).
    - If a halt opcode is seen, the halt instruction still enters IF/ID (ifid_vld=1), pc is not incremented, and state<=HALT.
- In HALT:
  - halted=1; im_rd_en=0; pc frozen.
  - br_taken ignored.
  - On the first edge in HALT, IF/ID loads NOP_INSTR with ifid_vld=0; it holds that thereafter unless stall=1.
- Latency: an address presented in cycle N appears on ifid_* after edge N+1 (one cycle). A redirect issued at edge N fetches br_target in cycle N+1.
- Reset mid-stall or mid-redirect: all state is discarded immediately; the first fetch after deassertion is RESET_PC.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[15:0], stall_cnt[15:0], flush_cnt[15:0].
  - fetch_cnt increments on each advance.
  - stall_cnt increments on each FETCH cycle with stall=1 & br_taken=0.
  - flush_cnt increments on each br_taken accepted in FETCH.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package wisc_pkg:
  - Constants: NOP_INSTR, HALT_OPCODE, opcode field bounds [15:12].
  - Fetch-state enum {FETCH, HALT}.
  - Parameters default from these constants.
- One natural sub-module: fetch_perf_cnt, a saturating counter triple instantiated only under FETCH_PERF_CNT_EN.

Test Plan:
- Sequential fetch: rst, then memory 0..3 = 16'h1111,16'h2222,16'h3333,16'h4444 → ifid_instr follows in order one cycle after each im_addr, ifid_pc_plus1=1,2,3,4, ifid_vld=1.
- Stall: stall high 3 cycles while pc=2 → im_rd_en=0, pc stays 2, ifid_instr stays 16'h2222; resumes with 16'h3333.
- Branch: br_taken=1, br_target=16'h0040 at pc=5, stall=1 simultaneously → next im_addr=16'h0040, one bubble (ifid_vld=0, ifid_instr=0), then mem[0x40].
- Halt: mem[6]=16'hF000 → ifid_instr=16'hF000 vld=1, next edge halted=1, im_rd_en=0, pc=6 forever; later br_taken ignored.
- Wrap and reset: branch to 16'hFFFF, advance → pc=16'h0000, ifid_pc_plus1=0. Assert rst mid-stall → outputs at reset values asynchronously, refetch from 16'h0000.
- Perf counters (FETCH_PERF_CNT_EN): 10 advances, 4 stalls, 2 flushes → fetch_cnt=10, stall_cnt=4, flush_cnt=2. Preload to 16'hFFFF → counters stay at 16'hFFFF.
